d_cache_wb_nway: RTL and testbench



---
 rtl/d_cache_pkg.sv | 48 ++++
 rtl/d_cache_lru.sv | 61 ++++++
 rtl/d_cache_wb_nway.sv | 260 ++++++++++++++++++++++++++
 tb/tb_d_cache_wb_nway.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d_cache_pkg
//  Description : Shared types, size codes, write-mask helper and derived
//                geometry for the N-way write-back data cache.
//                Optional feature macro: D_CACHE_UNCACHED_EN (enables ST_UC).
//  Revision    : 1.0 - initial release
// ============================================================================
package d_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RF   = 2'd2,
    ST_UC   = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int DEF_OFFSET_WIDTH = 4;
  localparam int DEF_WAYS         = 4;

  // Words per line for a given byte-offset width.
  function automatic int line_words_f(input int offset_width);
    return 1 << (offset_width - 2);
  endfunction

  // Width of a way index / age counter; at least one bit.
  function automatic int way_w_f(input int ways);
    return (ways <= 2) ? 1 : $clog2(ways);
  endfunction

  localparam int LINE_WORDS = line_words_f(DEF_OFFSET_WIDTH);
  localparam int WAY_W      = way_w_f(DEF_WAYS);

  // Byte-lane enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] wr_mask_f(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: wr_mask_f = 4'b0001 << a;
      SIZE_HALF: wr_mask_f = a[1] ? 4'b1100 : 4'b0011;
      default:   wr_mask_f = 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/d_cache_lru.sv
`default_nettype none
// ============================================================================
//  Module      : d_cache_lru
//  Description : Per-set true-LRU age counters. Ages form a permutation of
//                0..WAYS-1 per set; the oldest way (age WAYS-1) is the victim
//                unless an invalid way exists (lowest invalid index wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module d_cache_lru
  import d_cache_pkg::*;
#(
  parameter int WAYS        = 4,
  parameter int INDEX_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INDEX_WIDTH-1:0]     rd_index,
  input  logic [WAYS-1:0]            rd_valid,
  output logic [way_w_f(WAYS)-1:0]   victim,
  input  logic                       upd_en,
  input  logic [INDEX_WIDTH-1:0]     upd_index,
  input  logic [way_w_f(WAYS)-1:0]   upd_way
);

  localparam int WW   = way_w_f(WAYS);
  localparam int SETS = 1 << INDEX_WIDTH;

  logic [WW-1:0] r_age [SETS][WAYS];
  logic [WW-1:0] w_old_age;

  assign w_old_age = r_age[upd_index][upd_way];

  // Victim: oldest way, overridden by the lowest-index invalid way.
  always_comb begin
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_age[rd_index][w] == WW'(WAYS - 1)) victim = WW'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!rd_valid[w]) victim = WW'(w);
    end
  end

  // Accessed way becomes youngest; ways younger than its old age step older.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) r_age[s][w] <= WW'(w);
      end
    end else if (upd_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WW'(w) == upd_way)
          r_age[upd_index][w] <= '0;
        else if (r_age[upd_index][w] < w_old_age)
          r_age[upd_index][w] <= r_age[upd_index][w] + WW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/d_cache_wb_nway.sv
`default_nettype none
// ============================================================================
//  Module      : d_cache_wb_nway
//  Description : N-way set-associative write-back / write-allocate data cache
//                with multi-word lines and true LRU, between the core data
//                port and the bridge (SRAM-like req/addr_ok/data_ok).
//                Optional feature macro: D_CACHE_UNCACHED_EN (kseg1 bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
module d_cache_wb_nway
  import d_cache_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4,
  parameter int WAYS         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int NWORDS = line_words_f(OFFSET_WIDTH);
  localparam int WW     = way_w_f(WAYS);
  localparam int BW     = OFFSET_WIDTH - 2;
  localparam int TAG_W  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS   = 1 << INDEX_WIDTH;

  state_t                 r_state;
  logic [TAG_W-1:0]       r_tag   [SETS][WAYS];
  logic [WAYS-1:0]        r_valid [SETS];
  logic [WAYS-1:0]        r_dirty [SETS];
  logic [31:0]            r_data  [SETS][WAYS][NWORDS];

  logic [TAG_W-1:0]       r_tag_save, r_victim_tag;
  logic [INDEX_WIDTH-1:0] r_index_save;
  logic [WW-1:0]          r_victim;
  logic [BW-1:0]          r_beat;
  logic                   r_addr_done;
  logic                   r_req, r_wr;
  logic [1:0]             r_size;
  logic [31:0]            r_addr, r_wdata;

  logic [TAG_W-1:0]       w_tag;
  logic [INDEX_WIDTH-1:0] w_index;
  logic [BW-1:0]          w_word, w_next_beat;
  logic                   w_hit, w_uncached, w_hit_acc, w_miss_acc;
  logic [WW-1:0]          w_hit_way, w_victim;
  logic                   w_beat_done, w_last, w_rf_done;
  logic [31:0]            w_sel_word, w_merged;
  logic [3:0]             w_mask;

  assign w_tag       = cpu_data_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
  assign w_index     = cpu_data_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign w_word      = cpu_data_addr[OFFSET_WIDTH-1:2];
  assign w_next_beat = r_beat + BW'(1);
  assign w_last      = (r_beat == BW'(NWORDS - 1));
  assign w_mask      = wr_mask_f(cpu_data_size, cpu_data_addr[1:0]);
  assign w_sel_word  = r_data[w_index][w_hit_way][w_word];

`ifdef D_CACHE_UNCACHED_EN
  assign w_uncached = (cpu_data_addr[31:29] == 3'b101);
`else
  assign w_uncached = 1'b0;
`endif

  assign w_hit_acc  = !rst && (r_state == ST_IDLE) && cpu_data_req && !w_uncached && w_hit;
  assign w_miss_acc = !rst && (r_state == ST_IDLE) && cpu_data_req && !w_uncached && !w_hit;

  // A beat completes on data_ok once its address was (or is now) accepted.
  assign w_beat_done = !rst && (r_state != ST_IDLE) && cache_data_data_ok &&
                       (r_addr_done || (r_req && cache_data_addr_ok));
  assign w_rf_done   = (r_state == ST_RF) && w_beat_done && w_last;

  assign cache_data_req   = r_req;
  assign cache_data_wr    = r_wr;
  assign cache_data_size  = r_size;
  assign cache_data_addr  = r_addr;
  assign cache_data_wdata = r_wdata;

  // Tag compare across ways; lowest matching way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(w);
      end
    end
  end

  // Byte-lane merge of store data into the hit word.
  always_comb begin
    w_merged = w_sel_word;
    for (int b = 0; b < 4; b++) begin
      if (w_mask[b]) w_merged[8*b +: 8] = cpu_data_wdata[8*b +: 8];
    end
  end

  // Core-side handshake: zero-wait on hits, mirrored bridge in bypass.
  always_comb begin
    cpu_data_addr_ok = w_hit_acc;
    cpu_data_data_ok = w_hit_acc;
    cpu_data_rdata   = w_sel_word;
`ifdef D_CACHE_UNCACHED_EN
    if (r_state == ST_UC) begin
      cpu_data_addr_ok = r_req && cache_data_addr_ok;
      cpu_data_data_ok = w_beat_done;
      cpu_data_rdata   = cache_data_rdata;
    end
`endif
  end

  d_cache_lru #(
    .WAYS        (WAYS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_lru (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (w_index),
    .rd_valid  (r_valid[w_index]),
    .victim    (w_victim),
    .upd_en    (w_hit_acc || w_rf_done),
    .upd_index (w_rf_done ? r_index_save : w_index),
    .upd_way   (w_rf_done ? r_victim : w_hit_way)
  );

  // Data array writes: store hits and refill beats (never in the same cycle).
  always_ff @(posedge clk) begin
    if (w_hit_acc && cpu_data_wr)
      r_data[w_index][w_hit_way][w_word] <= w_merged;
    else if ((r_state == ST_RF) && w_beat_done)
      r_data[r_index_save][r_victim][r_beat] <= cache_data_rdata;
  end

  // Miss FSM: write back dirty victim, refill line, update tag state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
      r_beat       <= '0;
      r_addr_done  <= 1'b0;
      r_req        <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= SIZE_WORD;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_tag_save   <= '0;
      r_victim_tag <= '0;
      r_index_save <= '0;
      r_victim     <= '0;
    end else begin
      if (r_state != ST_IDLE) begin
        if (r_req && cache_data_addr_ok) begin
          r_req       <= 1'b0;
          r_addr_done <= 1'b1;
        end
        if (w_beat_done) r_addr_done <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_hit_acc && cpu_data_wr) begin
            r_dirty[w_index][w_hit_way] <= 1'b1;
          end else if (w_miss_acc) begin
            r_tag_save   <= w_tag;
            r_index_save <= w_index;
            r_victim     <= w_victim;
            r_victim_tag <= r_tag[w_index][w_victim];
            r_beat       <= '0;
            r_addr_done  <= 1'b0;
            r_req        <= 1'b1;
            r_size       <= SIZE_WORD;
            if (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim]) begin
              r_state <= ST_WB;
              r_wr    <= 1'b1;
              r_addr  <= {r_tag[w_index][w_victim], w_index, {BW{1'b0}}, 2'b00};
              r_wdata <= r_data[w_index][w_victim][0];
            end else begin
              r_state <= ST_RF;
              r_wr    <= 1'b0;
              r_addr  <= {w_tag, w_index, {BW{1'b0}}, 2'b00};
              r_wdata <= '0;
            end
          end
`ifdef D_CACHE_UNCACHED_EN
          else if (cpu_data_req && w_uncached) begin
            r_state     <= ST_UC;
            r_addr_done <= 1'b0;
            r_req       <= 1'b1;
            r_wr        <= cpu_data_wr;
            r_size      <= cpu_data_size;
            r_addr      <= cpu_data_addr;
            r_wdata     <= cpu_data_wdata;
          end
`endif
        end
        ST_WB: begin
          if (w_beat_done) begin
            r_req <= 1'b1;
            if (w_last) begin
              r_state <= ST_RF;
              r_beat  <= '0;
              r_wr    <= 1'b0;
              r_addr  <= {r_tag_save, r_index_save, {BW{1'b0}}, 2'b00};
            end else begin
              r_beat  <= w_next_beat;
              r_addr  <= {r_victim_tag, r_index_save, w_next_beat, 2'b00};
              r_wdata <= r_data[r_index_save][r_victim][w_next_beat];
            end
          end
        end
        ST_RF: begin
          if (w_beat_done) begin
            if (w_last) begin
              r_state                          <= ST_IDLE;
              r_beat                           <= '0;
              r_valid[r_index_save][r_victim]  <= 1'b1;
              r_dirty[r_index_save][r_victim]  <= 1'b0;
              r_tag[r_index_save][r_victim]    <= r_tag_save;
            end else begin
              r_beat <= w_next_beat;
              r_req  <= 1'b1;
              r_addr <= {r_tag_save, r_index_save, w_next_beat, 2'b00};
            end
          end
        end
`ifdef D_CACHE_UNCACHED_EN
        ST_UC: begin
          if (w_beat_done) begin
            r_state <= ST_IDLE;
            r_size  <= SIZE_WORD;
            r_wr    <= 1'b0;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_d_cache_wb_nway.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_cache_wb_nway
//  Description : Self-checking bench for d_cache_wb_nway (4 ways, 16-byte
//                lines, 128 sets). A queue-per-set LRU reference model and an
//                architectural memory predict load data and bridge traffic.
//                Optional feature macro: D_CACHE_UNCACHED_EN (bypass test).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_d_cache_wb_nway;

  typedef struct {
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk, rst;
  logic        cpu_data_req, cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic        cache_data_req, cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
  logic        cache_data_addr_ok, cache_data_data_ok;

  int n_tests = 0;
  int n_fail  = 0;

  txn_t act_q[$];
  txn_t exp_q[$];
  int          g_n_act;
  logic [31:0] g_first_addr;
  int          br_mode = 0;   // 0 random delays, 1 fixed 3/5, 2 same-cycle

  logic [31:0] bmem   [logic [31:0]];
  logic [31:0] golden [logic [31:0]];
  logic [20:0] set_tags [128][$];
  bit          dirty_line [logic [27:0]];

  d_cache_wb_nway #(.INDEX_WIDTH(7), .OFFSET_WIDTH(4), .WAYS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .cpu_data_req       (cpu_data_req),
    .cpu_data_wr        (cpu_data_wr),
    .cpu_data_size      (cpu_data_size),
    .cpu_data_addr      (cpu_data_addr),
    .cpu_data_wdata     (cpu_data_wdata),
    .cpu_data_rdata     (cpu_data_rdata),
    .cpu_data_addr_ok   (cpu_data_addr_ok),
    .cpu_data_data_ok   (cpu_data_data_ok),
    .cache_data_req     (cache_data_req),
    .cache_data_wr      (cache_data_wr),
    .cache_data_size    (cache_data_size),
    .cache_data_addr    (cache_data_addr),
    .cache_data_wdata   (cache_data_wdata),
    .cache_data_rdata   (cache_data_rdata),
    .cache_data_addr_ok (cache_data_addr_ok),
    .cache_data_data_ok (cache_data_data_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] bmem_rd(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return golden.exists(a) ? golden[a] : init_word(a);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    return 32'h0000_00FF << (8 * a);
      2'd1:    return a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Bridge/memory responder with configurable handshake delays.
  initial begin
    bit          pending;
    int          acnt, dcnt;
    logic [31:0] pdata, wa;
    pending = 0;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata   = '0;
    acnt = 0;
    forever begin
      @(posedge clk); #1;
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      cache_data_rdata   = $urandom;
      if (rst) begin
        pending = 0;
      end else if (pending) begin
        if (dcnt == 0) begin
          cache_data_data_ok = 1'b1;
          cache_data_rdata   = pdata;
          pending = 0;
        end else dcnt--;
      end else if (cache_data_req) begin
        if (acnt == 0) begin
          cache_data_addr_ok = 1'b1;
          act_q.push_back('{cache_data_wr, cache_data_size, cache_data_addr, cache_data_wdata});
          wa = {cache_data_addr[31:2], 2'b00};
          if (cache_data_wr) begin
            bmem[wa] = (bmem_rd(wa) & ~lane_mask(cache_data_size, cache_data_addr[1:0])) |
                       (cache_data_wdata & lane_mask(cache_data_size, cache_data_addr[1:0]));
          end
          pdata = bmem_rd(wa);
          dcnt = (br_mode == 1) ? 5 : (br_mode == 2) ? 0 : $urandom_range(0, 5);
          acnt = (br_mode == 1) ? 3 : (br_mode == 2) ? 0 : $urandom_range(0, 3);
          if (dcnt == 0) begin
            cache_data_data_ok = 1'b1;
            cache_data_rdata   = pdata;
          end else begin
            pending = 1;
            dcnt--;
          end
        end else acnt--;
      end
    end
  end

  // Reference model: one access against per-set MRU-first tag queues.
  task automatic model_access(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, output bit hit, output logic [31:0] rdata);
    logic [27:0] line, vline;
    logic [6:0]  set;
    logic [20:0] tag, vt;
    logic [31:0] wa, a, m;
    int pos;
    line = addr[31:4];
    set  = addr[10:4];
    tag  = addr[31:11];
    pos  = -1;
    foreach (set_tags[set][i]) if (set_tags[set][i] == tag && pos < 0) pos = i;
    hit = (pos >= 0);
    if (hit) begin
      set_tags[set].delete(pos);
    end else begin
      if (set_tags[set].size() == 4) begin
        vt    = set_tags[set].pop_back();
        vline = {vt, set};
        if (dirty_line.exists(vline)) begin
          for (int b = 0; b < 4; b++) begin
            a = {vline, 4'b0000} + 32'(4 * b);
            exp_q.push_back('{1'b1, 2'd2, a, gold_rd(a)});
          end
          dirty_line.delete(vline);
        end
      end
      for (int b = 0; b < 4; b++)
        exp_q.push_back('{1'b0, 2'd2, {line, 4'b0000} + 32'(4 * b), 32'h0});
    end
    set_tags[set].push_front(tag);
    wa = {addr[31:2], 2'b00};
    if (wr) begin
      m = lane_mask(size, addr[1:0]);
      golden[wa] = (gold_rd(wa) & ~m) | (wdata & m);
      dirty_line[line] = 1'b1;
    end
    rdata = gold_rd(wa);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 128; s++) set_tags[s].delete();
    dirty_line.delete();
    golden = bmem;
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_log();
    int n;
    g_n_act      = act_q.size();
    g_first_addr = (act_q.size() > 0) ? act_q[0].addr : 32'hFFFF_FFFF;
    check("txn_count", act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("txn_wr",   {31'd0, act_q[i].wr}, {31'd0, exp_q[i].wr});
      check("txn_addr", act_q[i].addr, exp_q[i].addr);
      check("txn_size", {30'd0, act_q[i].size}, {30'd0, exp_q[i].size});
      if (exp_q[i].wr) check("txn_wdata", act_q[i].data, exp_q[i].data);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  // Starts and ends just after a rising edge.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    cpu_data_req = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_bridge_req", {31'd0, cache_data_req}, 32'd0);
    check("rst_cpu_addr_ok", {31'd0, cpu_data_addr_ok}, 32'd0);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    model_reset();
  endtask

  task automatic access(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got);
    bit          exp_hit, done, aok;
    logic [31:0] exp_rd;
    int          cyc;
    model_access(wr, size, addr, wdata, exp_hit, exp_rd);
    cpu_data_req   = 1'b1;
    cpu_data_wr    = wr;
    cpu_data_size  = size;
    cpu_data_addr  = addr;
    cpu_data_wdata = wdata;
    cyc = 0; done = 0; aok = 0; got = '0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      if (cpu_data_data_ok) begin
        done = 1;
        got  = cpu_data_rdata;
        aok  = cpu_data_addr_ok;
      end else cyc++;
    end
    @(posedge clk); #2;
    cpu_data_req = 1'b0;
    check("access_done", {31'd0, done}, 32'd1);
    check("addr_ok_with_data_ok", {31'd0, aok}, 32'd1);
    if (exp_hit) check("hit_zero_wait", cyc, 0);
    else         check("miss_waits", {31'd0, cyc != 0}, 32'd1);
    if (!wr) check("load_data", got, exp_rd);
    compare_log();
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic [1:0]  sz;
    int          cyc;
    rst = 1'b1;
    cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'd2;
    cpu_data_addr = '0;  cpu_data_wdata = '0;
    bmem[32'h0000_1000] = 32'h1122_3344;
    @(posedge clk); #2;
    do_reset(3);
    check("reset_data_ok", {31'd0, cpu_data_data_ok}, 32'd0);

    // Cold load, then a zero-wait hit in the same line.
    access(1'b0, 2'd2, 32'h0000_1004, 32'h0, rd);
    check("cold_first_read_addr", g_first_addr, 32'h0000_1000);
    check("cold_read_count", g_n_act, 4);
    access(1'b0, 2'd2, 32'h0000_1008, 32'h0, rd);

    // Byte store merge into a filled word.
    access(1'b1, 2'd0, 32'h0000_1001, 32'hABAB_ABAB, rd);
    access(1'b0, 2'd2, 32'h0000_1000, 32'h0, rd);
    check("store_byte_merge", rd, 32'h1122_AB44);

    // LRU eviction in set 1: B is filled second, dirtied, and later evicted.
    access(1'b0, 2'd2, 32'h0000_4010, 32'h0, rd);
    access(1'b1, 2'd2, 32'h0000_4814, 32'hCAFE_F00D, rd);
    access(1'b0, 2'd2, 32'h0000_5010, 32'h0, rd);
    access(1'b0, 2'd2, 32'h0000_5810, 32'h0, rd);
    access(1'b0, 2'd2, 32'h0000_4018, 32'h0, rd);
    access(1'b0, 2'd2, 32'h0000_6010, 32'h0, rd);
    check("lru_victim_wb_addr", g_first_addr, 32'h0000_4810);
    check("lru_evict_txns", g_n_act, 8);
    access(1'b0, 2'd2, 32'h0000_4814, 32'h0, rd);
    check("evicted_data_back", rd, 32'hCAFE_F00D);

    // Fixed slow handshake and same-cycle addr_ok/data_ok.
    br_mode = 1;
    access(1'b0, 2'd2, 32'h0000_7020, 32'h0, rd);
    br_mode = 2;
    access(1'b1, 2'd1, 32'h0000_7822, 32'h5A5A_5A5A, rd);
    access(1'b0, 2'd2, 32'h0000_7820, 32'h0, rd);

    // Randomized traffic over four sets and eight tags.
    for (int i = 0; i < 250; i++) begin
      br_mode = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 2));
      a  = (32'($urandom_range(0, 7)) << 11) | (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2) a[1:0] = 2'b00;
      wd = $urandom;
      access(1'($urandom_range(0, 1)), sz, a, wd, rd);
    end
    br_mode = 0;

    // Reset while refilling beat 2 abandons the line.
    do_reset(2);
    cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_size = 2'd2;
    cpu_data_addr = 32'h0000_3004;
    cyc = 0;
    while (act_q.size() < 3 && cyc < 500) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("rf_reached_beat2", {31'd0, act_q.size() >= 3}, 32'd1);
    do_reset(2);
    access(1'b0, 2'd2, 32'h0000_3004, 32'h0, rd);
    check("refetch_after_rst", g_n_act, 4);

`ifdef D_CACHE_UNCACHED_EN
    // Uncached half store through the bypass path.
    access(1'b0, 2'd2, 32'h0000_3008, 32'h0, rd);
    exp_q.push_back('{1'b1, 2'd1, 32'hA000_0002, 32'hBEEF_BEEF});
    cpu_data_req = 1'b1; cpu_data_wr = 1'b1; cpu_data_size = 2'd1;
    cpu_data_addr = 32'hA000_0002; cpu_data_wdata = 32'hBEEF_BEEF;
    begin
      bit seen_d;
      seen_d = 0; cyc = 0;
      while (!seen_d && cyc < 500) begin
        @(negedge clk);
        if (cpu_data_addr_ok) cpu_data_req = 1'b0;
        if (cpu_data_data_ok) seen_d = 1;
        cyc++;
      end
      check("uc_done", {31'd0, seen_d}, 32'd1);
    end
    cpu_data_req = 1'b0;
    @(posedge clk); #2;
    compare_log();
    check("uc_mem", bmem_rd(32'hA000_0000), (init_word(32'hA000_0000) & 32'h0000_FFFF) | 32'hBEEF_0000);
    access(1'b0, 2'd2, 32'h0000_3008, 32'h0, rd);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
